// File: rtl/imem_loader_if.sv
// Byte-stream / imem-write bundle between a program source and imem_loader.
// master drives the stream and start; slave is the loader itself.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_hold;
  logic              done;
  logic              error;
  logic [6:0]        words_loaded;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata,
    input  core_hold, done, error, words_loaded
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata,
    output core_hold, done, error, words_loaded
  );
endinterface

// File: rtl/imem_loader.sv
// Program-image loader: takes "count, payload, checksum" bytes, packs
// little-endian words into instruction memory at word-aligned byte
// addresses and keeps the core held in reset until a valid image is in.
module imem_loader #(
  parameter int                ADDR_W    = 8,
  parameter int                MAX_WORDS = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic          clk,
  input  logic          reset,
  imem_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GET_CNT  = 3'd1,
    S_GET_DATA = 3'd2,
    S_WRITE    = 3'd3,
    S_GET_SUM  = 3'd4,
    S_DONE     = 3'd5,
    S_ERROR    = 3'd6
  } state_t;

  // Running image checksum: byte-wise XOR of every payload byte.
  function automatic logic [7:0] csum_step(input logic [7:0] acc,
                                           input logic [7:0] b);
    return acc ^ b;
  endfunction

  state_t            state_r;
  logic [7:0]        cnt_r;
  logic [1:0]        lane_r;
  logic [23:0]       word_r;
  logic [7:0]        csum_r;
  logic              in_ready_r;
  logic              imem_we_r;
  logic [ADDR_W-1:0] imem_addr_r;
  logic [31:0]       imem_wdata_r;
  logic              core_hold_r;
  logic              done_r;
  logic              error_r;
  logic [6:0]        words_loaded_r;

  logic              accept_s;
  logic              cnt_bad_s;
  logic [6:0]        wl_next_s;
  logic              last_word_s;
  logic [ADDR_W-1:0] write_addr_s;

  // in_ready is registered, so a byte moves exactly when both sides agree.
  assign accept_s     = bus.in_valid & in_ready_r;
  assign cnt_bad_s    = (bus.in_data == 8'd0) || (bus.in_data > 8'(MAX_WORDS));
  assign wl_next_s    = words_loaded_r + 7'd1;
  assign last_word_s  = ({1'b0, wl_next_s} == cnt_r);
  // Word index times four, wrapping naturally in the address width.
  assign write_addr_s = BASE_ADDR + ADDR_W'({words_loaded_r, 2'b00});

  // Loader FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r        <= S_IDLE;
      cnt_r          <= 8'd0;
      lane_r         <= 2'd0;
      word_r         <= 24'd0;
      csum_r         <= 8'd0;
      in_ready_r     <= 1'b0;
      imem_we_r      <= 1'b0;
      imem_addr_r    <= BASE_ADDR;
      imem_wdata_r   <= 32'd0;
      core_hold_r    <= 1'b1;
      done_r         <= 1'b0;
      error_r        <= 1'b0;
      words_loaded_r <= 7'd0;
    end else begin
      case (state_r)
        // Idle and both terminal states share the same restart path.
        S_IDLE, S_DONE, S_ERROR: begin
          if (bus.start) begin
            state_r        <= S_GET_CNT;
            in_ready_r     <= 1'b1;
            core_hold_r    <= 1'b1;
            done_r         <= 1'b0;
            error_r        <= 1'b0;
            words_loaded_r <= 7'd0;
            csum_r         <= 8'd0;
            lane_r         <= 2'd0;
          end else begin
            in_ready_r <= 1'b0;
          end
        end

        S_GET_CNT: begin
          if (accept_s) begin
            cnt_r <= bus.in_data;
            if (cnt_bad_s) begin
              state_r     <= S_ERROR;
              in_ready_r  <= 1'b0;
              error_r     <= 1'b1;
              core_hold_r <= 1'b1;
            end else begin
              state_r <= S_GET_DATA;
              lane_r  <= 2'd0;
            end
          end else begin
            state_r <= S_GET_CNT;
          end
        end

        S_GET_DATA: begin
          if (accept_s) begin
            csum_r <= csum_step(csum_r, bus.in_data);
            lane_r <= lane_r + 2'd1;
            case (lane_r)
              2'd0: word_r[7:0]   <= bus.in_data;
              2'd1: word_r[15:8]  <= bus.in_data;
              2'd2: word_r[23:16] <= bus.in_data;
              default: begin
                // Last lane goes straight into the write word.
                state_r      <= S_WRITE;
                in_ready_r   <= 1'b0;
                imem_we_r    <= 1'b1;
                imem_wdata_r <= {bus.in_data, word_r};
                imem_addr_r  <= write_addr_s;
              end
            endcase
          end else begin
            state_r <= S_GET_DATA;
          end
        end

        S_WRITE: begin
          imem_we_r      <= 1'b0;
          in_ready_r     <= 1'b1;
          lane_r         <= 2'd0;
          words_loaded_r <= wl_next_s;
          if (last_word_s) begin
            state_r <= S_GET_SUM;
          end else begin
            state_r <= S_GET_DATA;
          end
        end

        S_GET_SUM: begin
          if (accept_s) begin
            in_ready_r <= 1'b0;
            if (bus.in_data == csum_r) begin
              state_r     <= S_DONE;
              done_r      <= 1'b1;
              core_hold_r <= 1'b0;
            end else begin
              state_r     <= S_ERROR;
              error_r     <= 1'b1;
              core_hold_r <= 1'b1;
            end
          end else begin
            state_r <= S_GET_SUM;
          end
        end

        default: begin
          state_r     <= S_IDLE;
          in_ready_r  <= 1'b0;
          imem_we_r   <= 1'b0;
          core_hold_r <= 1'b1;
          done_r      <= 1'b0;
          error_r     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready     = in_ready_r;
  assign bus.imem_we      = imem_we_r;
  assign bus.imem_addr    = imem_addr_r;
  assign bus.imem_wdata   = imem_wdata_r;
  assign bus.core_hold    = core_hold_r;
  assign bus.done         = done_r;
  assign bus.error        = error_r;
  assign bus.words_loaded = words_loaded_r;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a load-level model predicts the write
// sequence and final status; a monitor checks each imem write as it occurs.
module tb_imem_loader;

  logic clk;
  logic reset;

  imem_loader_if #(.ADDR_W(8)) bus ();

  imem_loader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        mon_e;
  logic [7:0] payload[$];
  int         checks   = 0;
  int         failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the next predicted write.
  always @(negedge clk) begin
    if (reset && bus.imem_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write addr=%h data=%h expected=none",
                 bus.imem_addr, bus.imem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("write_addr", {24'd0, bus.imem_addr}, {24'd0, mon_e.addr});
        chk("write_data", bus.imem_wdata, mon_e.data);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        if (bus.in_ready) begin
          @(posedge clk);
          ok = 1'b1;
        end
      end
    end
    #1 bus.in_valid = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_timeout byte=%h accepted=0 expected=1", b);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // One complete load of the bytes in `payload` with count n.
  task automatic run_load(input logic [7:0] n, input bit gaps,
                          input bit bad_sum, input bit mid_start);
    bit         valid;
    logic [7:0] sum;
    logic [7:0] sum_byte;
    wr_t        w;
    valid = (n >= 8'd1) && (n <= 8'd64);
    sum   = 8'd0;
    if (valid) begin
      for (int i = 0; i < int'(n); i++) begin
        w.addr = 8'((4 * i) % 256);
        w.data = {payload[4*i+3], payload[4*i+2], payload[4*i+1], payload[4*i]};
        exp_q.push_back(w);
      end
      for (int i = 0; i < 4 * int'(n); i++) sum = sum ^ payload[i];
    end
    sum_byte = bad_sum ? (sum ^ 8'h5A) : sum;

    pulse_start();
    chk("start_core_hold", {31'd0, bus.core_hold}, 32'd1);
    chk("start_done", {31'd0, bus.done}, 32'd0);
    chk("start_error", {31'd0, bus.error}, 32'd0);
    chk("start_words", {25'd0, bus.words_loaded}, 32'd0);
    chk("start_in_ready", {31'd0, bus.in_ready}, 32'd1);

    send_byte(n, gaps);
    if (valid) begin
      for (int i = 0; i < 4 * int'(n); i++) begin
        send_byte(payload[i], gaps);
        if (mid_start && i == 5) pulse_start();
      end
      send_byte(sum_byte, gaps);
    end

    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (bus.done || bus.error) break;
    end
    chk("end_done", {31'd0, bus.done}, {31'd0, valid && !bad_sum});
    chk("end_error", {31'd0, bus.error}, {31'd0, !(valid && !bad_sum)});
    chk("end_core_hold", {31'd0, bus.core_hold}, {31'd0, !(valid && !bad_sum)});
    chk("end_words", {25'd0, bus.words_loaded}, valid ? {24'd0, n} : 32'd0);
    chk("end_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("writes_pending", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
    chk({tag, "_imem_we"}, {31'd0, bus.imem_we}, 32'd0);
    chk({tag, "_imem_addr"}, {24'd0, bus.imem_addr}, 32'd0);
    chk({tag, "_imem_wdata"}, bus.imem_wdata, 32'd0);
    chk({tag, "_core_hold"}, {31'd0, bus.core_hold}, 32'd1);
    chk({tag, "_done"}, {31'd0, bus.done}, 32'd0);
    chk({tag, "_error"}, {31'd0, bus.error}, 32'd0);
    chk({tag, "_words"}, {25'd0, bus.words_loaded}, 32'd0);
  endtask

  task automatic fill_random(input int nbytes);
    payload.delete();
    for (int i = 0; i < nbytes; i++) payload.push_back(8'($urandom));
  endtask

  initial begin
    logic [31:0] wv;
    logic [7:0]  rn;
    reset        = 1'b0;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", {31'd0, bus.in_ready}, 32'd0);

    // Single word 0x00000013 with checksum 13.
    payload.delete();
    payload.push_back(8'h13); payload.push_back(8'h00);
    payload.push_back(8'h00); payload.push_back(8'h00);
    run_load(8'd1, 1'b0, 1'b0, 1'b0);

    // Three words 11111111/22222222/33333333, checksum 00.
    payload.delete();
    for (int wi = 1; wi <= 3; wi++) begin
      wv = 32'h11111111 * wi;
      for (int b = 0; b < 4; b++) payload.push_back(wv[8*b +: 8]);
    end
    run_load(8'd3, 1'b0, 1'b0, 1'b0);

    // Wrong checksum: writes still happen, then error.
    fill_random(8);
    run_load(8'd2, 1'b0, 1'b1, 1'b0);

    // Illegal counts.
    run_load(8'h00, 1'b0, 1'b0, 1'b0);
    run_load(8'h41, 1'b0, 1'b0, 1'b0);

    // Full 64-word image at full rate, then the same image with gaps.
    fill_random(256);
    run_load(8'd64, 1'b0, 1'b0, 1'b0);
    run_load(8'd64, 1'b1, 1'b0, 1'b0);

    // Start pulse in the middle of a load must be ignored.
    fill_random(16);
    run_load(8'd4, 1'b1, 1'b0, 1'b1);

    // Randomized loads.
    for (int k = 0; k < 6; k++) begin
      rn = 8'($urandom_range(1, 20));
      fill_random(4 * int'(rn));
      run_load(rn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
    end

    // Reset after 2 of 4 words.
    fill_random(16);
    for (int i = 0; i < 4; i++) begin
      mon_e.addr = 8'(4 * i);
      mon_e.data = {payload[4*i+3], payload[4*i+2], payload[4*i+1], payload[4*i]};
      exp_q.push_back(mon_e);
    end
    pulse_start();
    send_byte(8'd4, 1'b0);
    for (int i = 0; i < 8; i++) send_byte(payload[i], 1'b0);
    repeat (2) @(negedge clk);
    chk("pre_reset_words", {25'd0, bus.words_loaded}, 32'd2);
    chk("pre_reset_pending", exp_q.size(), 32'd2);
    reset = 1'b0;
    #1;
    check_reset_values("midload_reset");
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;

    // Normal load again after the abandoned one.
    fill_random(20);
    run_load(8'd5, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout reached=1 expected=0");
    $fatal(1);
  end

endmodule
